// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;

    localparam int unsigned MEM_BYTES_DEFAULT = 16384;
    localparam int unsigned HDR_BYTES         = 4;

    typedef enum logic [2:0] {
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    // True while the loader is still consuming the byte stream.
    function automatic logic is_receiving(state_t s);
        return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and memory write port of the boot loader.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    // Loader side: consumes the stream, drives the memory write port.
    modport master (
        input  rx_valid, rx_data,
        output rx_ready, wr_en, wr_addr, wr_data
    );

    // Environment side: byte receiver and instruction memory.
    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: parses length header, writes the image from address 0,
// verifies the 8-bit additive checksum and releases the CPU reset on success.
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.master bus,
    input  logic          start,
    output logic          cpu_rst_n,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_t            state_q, state_d;
    logic [31:0]       len_q, len_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [7:0]        sum_q, sum_d;
    logic [1:0]        hdr_idx_q, hdr_idx_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              rx_ready_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              cpu_rst_n_q;

    logic              accept;
    logic [31:0]       full_len;

    assign accept = bus.rx_valid && rx_ready_q;

    // Next-state and datapath updates; only an accepted byte or start moves anything.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        hdr_idx_d = hdr_idx_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        // Length as it stands once the current (last) header byte is merged in.
        full_len  = {bus.rx_data, len_q[23:0]};

        case (state_q)
            ST_LEN: begin
                if (accept) begin
                    len_d[{hdr_idx_q, 3'b000} +: 8] = bus.rx_data;
                    hdr_idx_d = hdr_idx_q + 2'd1;
                    if (hdr_idx_q == 2'(HDR_BYTES - 1)) begin
                        if (full_len > 32'(MEM_BYTES)) begin
                            state_d = ST_ERR;
                        end else if (full_len == '0) begin
                            state_d = ST_CSUM;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ADDR_W'(cnt_q);
                    wr_data_d = bus.rx_data;
                    cnt_d     = cnt_q + 32'd1;
                    sum_d     = sum_q + bus.rx_data;
                    if (cnt_q == len_q - 32'd1) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    state_d = (bus.rx_data == sum_q) ? ST_DONE : ST_ERR;
                end
            end
            ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d   = ST_LEN;
                    len_d     = '0;
                    cnt_d     = '0;
                    sum_d     = '0;
                    hdr_idx_d = '0;
                end
            end
            default: state_d = ST_LEN;
        endcase
    end

    // State, datapath and status registers; status is decoded from the next state
    // so handshake and flags change in the same cycle as the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LEN;
            len_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            hdr_idx_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rx_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            hdr_idx_q   <= hdr_idx_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rx_ready_q  <= is_receiving(state_d);
            busy_q      <= is_receiving(state_d);
            done_q      <= (state_d == ST_DONE);
            err_q       <= (state_d == ST_ERR);
            cpu_rst_n_q <= (state_d == ST_DONE);
        end
    end

    assign bus.rx_ready = rx_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign cpu_rst_n    = cpu_rst_n_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a stream-level reference model.
module tb_imem_loader;
    import loader_pkg::*;

    typedef logic [7:0] byte_t;
    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic cpu_rst_n, busy, done, err;

    imem_loader_if #(.ADDR_W(32)) bus ();

    imem_loader #(
        .MEM_BYTES (MEM_BYTES_DEFAULT),
        .ADDR_W    (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .start     (start),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    byte_t stream_q[$];
    wr_t   obs_q[$];
    int    acc_q[$];

    // Reference results for the current stream.
    int unsigned mdl_len;
    int unsigned mdl_used;
    int unsigned mdl_writes;
    bit          mdl_done;
    bit          mdl_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Record every memory write with the cycle it was visible in.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wr_t w;
            w.cyc  = cyc;
            w.addr = bus.wr_addr;
            w.data = bus.wr_data;
            obs_q.push_back(w);
            check_val("cpu_held_during_write", {31'd0, cpu_rst_n}, 32'd0);
        end
    end

    // Stream-level reference: what the byte stream means, not how it is parsed.
    task automatic model();
        logic [7:0] s;
        mdl_len = {stream_q[3], stream_q[2], stream_q[1], stream_q[0]};
        if (mdl_len > MEM_BYTES_DEFAULT) begin
            mdl_used   = 4;
            mdl_writes = 0;
            mdl_done   = 1'b0;
            mdl_err    = 1'b1;
        end else begin
            s = 8'd0;
            for (int unsigned k = 0; k < mdl_len; k++) s = s + stream_q[4 + k];
            mdl_used   = mdl_len + 5;
            mdl_writes = mdl_len;
            mdl_done   = (stream_q[4 + mdl_len] == s);
            mdl_err    = !mdl_done;
        end
    endtask

    task automatic build_image(input int unsigned len, input bit bad_sum);
        logic [7:0] s;
        logic [7:0] b;
        stream_q.delete();
        for (int unsigned k = 0; k < 4; k++) stream_q.push_back(byte_t'(len >> (8 * k)));
        if (len <= MEM_BYTES_DEFAULT) begin
            s = 8'd0;
            for (int unsigned k = 0; k < len; k++) begin
                b = byte_t'($urandom_range(0, 255));
                stream_q.push_back(b);
                s = s + b;
            end
            stream_q.push_back(bad_sum ? s + byte_t'($urandom_range(1, 255)) : s);
        end
    endtask

    function automatic bit pick_valid(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 2) == 0;
        return $urandom_range(0, 3) != 0;
    endfunction

    // Offer n_bytes of stream_q; ends in the cycle after the last acceptance edge.
    task automatic send(input int mode, input int unsigned n_bytes);
        int unsigned i = 0;
        int budget = int'(n_bytes) * 8 + 50;
        bit v;
        while (i < n_bytes && budget > 0) begin
            @(negedge clk);
            v = pick_valid(mode);
            bus.rx_data  = stream_q[i];
            bus.rx_valid = v;
            if (v && bus.rx_ready === 1'b1) begin
                if (i >= 4 && i < 4 + mdl_len) acc_q.push_back(cyc + 1);
                i++;
            end
            budget--;
        end
        check_val("bytes_accepted", i, n_bytes);
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic check_writes(input int unsigned n_exp);
        int unsigned n;
        #1;
        check_val("wr_count", obs_q.size(), n_exp);
        n = (obs_q.size() < n_exp) ? obs_q.size() : n_exp;
        for (int unsigned k = 0; k < n; k++) begin
            check_val("wr_addr", obs_q[k].addr, k);
            check_val("wr_data", {24'd0, obs_q[k].data}, {24'd0, stream_q[4 + k]});
            if (k < acc_q.size()) check_val("wr_latency", obs_q[k].cyc, acc_q[k]);
        end
        obs_q.delete();
        acc_q.delete();
    endtask

    task automatic check_status();
        check_val("done", {31'd0, done}, {31'd0, mdl_done});
        check_val("err", {31'd0, err}, {31'd0, mdl_err});
        check_val("cpu_rst_n", {31'd0, cpu_rst_n}, {31'd0, mdl_done});
        check_val("rx_ready_end", {31'd0, bus.rx_ready}, 32'd0);
        check_val("busy_end", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_reset_vals();
        check_val("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_err", {31'd0, err}, 32'd0);
        check_val("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        check_val("rst_wr_addr", bus.wr_addr, 32'd0);
        check_val("rst_wr_data", {24'd0, bus.wr_data}, 32'd0);
    endtask

    task automatic do_reset(input bit hold_valid);
        rst_n        = 1'b0;
        bus.rx_valid = hold_valid;
        bus.rx_data  = 8'hA5;
        repeat (2) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        obs_q.delete();
        acc_q.delete();
        @(negedge clk);
        check_val("ready_after_release", {31'd0, bus.rx_ready}, 32'd1);
        bus.rx_valid = 1'b0;
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("start_done", {31'd0, done}, 32'd0);
        check_val("start_err", {31'd0, err}, 32'd0);
        check_val("start_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        check_val("start_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
    endtask

    // Once halted, a persistent valid must not be taken.
    task automatic check_no_more_accept();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.rx_valid = 1'b1;
            bus.rx_data  = 8'h5A;
            check_val("halted_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        #1;
        check_val("halted_writes", obs_q.size(), 32'd0);
    endtask

    task automatic run_stream(input int mode);
        model();
        send(mode, mdl_used);
        check_status();
        check_writes(mdl_writes);
        if (mdl_err) check_no_more_accept();
    endtask

    task automatic set_nominal(input byte_t last);
        stream_q = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                     8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
        stream_q[12] = last;
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        do_reset(1'b0);
        set_nominal(8'hB6);
        run_stream(0);

        // Valid already asserted while rx_ready is still low after reset.
        do_reset(1'b1);
        set_nominal(8'hB6);
        run_stream(1);

        start_pulse();
        set_nominal(8'hB5);
        run_stream(0);

        start_pulse();
        stream_q = '{8'h01, 8'h40, 8'h00, 8'h00};
        run_stream(0);

        start_pulse();
        stream_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_stream(0);
        start_pulse();
        set_nominal(8'hB6);
        run_stream(0);

        // Reset after three data bytes, then a clean reload.
        start_pulse();
        set_nominal(8'hB6);
        model();
        send(0, 7);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        check_writes(3);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_val("no_write_after_abort", obs_q.size(), 32'd0);
        run_stream(0);

        // Largest legal image.
        start_pulse();
        build_image(MEM_BYTES_DEFAULT, 1'b0);
        run_stream(0);

        for (int t = 0; t < 14; t++) begin
            start_pulse();
            if ($urandom_range(0, 5) == 0)
                build_image(MEM_BYTES_DEFAULT + 1 + $urandom_range(0, 1000), 1'b0);
            else
                build_image($urandom_range(0, 40), $urandom_range(0, 3) == 0);
            run_stream(int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
